sprite_rom_arbiter: RTL and testbench

- Shares the single combinational sprite ROM between the screen renderers: background tiles, player sprite and enemy sprites.
- Grants are registered, and arbitration is round-robin with a bounded burst length.
- Read data is registered and tagged per requester, so each renderer can prefetch sprite rows into its own line registers.
- Sits between the renderer blocks and the one sprite_rom instance in the top-level color path.

---
 rtl/sprite_rom_arbiter.sv | 155 +++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one combinational sprite ROM between the
// background, player and enemy renderers. Registered one-hot grant,
// round-robin ownership with a bounded burst while others wait, and a
// registered, per-requester tagged read-data return one cycle after the
// address is presented.
module sprite_rom_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     owner_nxt;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     ptr_nxt;
    logic [IDX_W-1:0]     rel_ptr;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [NUM_REQ-1:0]   gnt_nxt;
    logic [NUM_REQ-1:0]   rd_valid_nxt;
    logic [NUM_REQ-1:0]   others;
    logic [DATA_W-1:0]    rd_data_nxt;
    logic                 read;
    logic                 release_now;

    // One-hot vector with bit idx set.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set bit of cand searching upward from start with wrap-around.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] cand,
                                              input logic [IDX_W-1:0]   start);
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] sel;
        logic             found;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            sel = IDX_W'((int'(start) + k) % int'(NUM_REQ));
            if (!found && cand[sel]) begin
                win   = sel;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // State and output registers; reset drops any in-flight read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            gnt      <= gnt_nxt;
            rd_valid <= rd_valid_nxt;
            rd_data  <= rd_data_nxt;
        end
    end

    // Next-state: arbitration, burst counting, release and zero-bubble handoff.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        gnt_nxt      = gnt;
        rd_valid_nxt = '0;
        rd_data_nxt  = rd_data;
        others       = req & ~onehot(owner);
        rel_ptr      = (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
        release_now  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt = ST_OWNED;
                    owner_nxt = pick(req, ptr);
                    gnt_nxt   = onehot(pick(req, ptr));
                    cnt_nxt   = '0;
                end
            end
            ST_OWNED: begin
                if (read) begin
                    rd_valid_nxt = onehot(owner);
                    rd_data_nxt  = rom_data;
                end
                release_now = !req[owner] || (read && (cnt == CNT_LAST) && (|others));
                if (release_now) begin
                    ptr_nxt = rel_ptr;
                    cnt_nxt = '0;
                    if (|others) begin
                        owner_nxt = pick(others, rel_ptr);
                        gnt_nxt   = onehot(pick(others, rel_ptr));
                    end else begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = '0;
                    end
                end else if (read) begin
                    cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: read-cycle detect and ROM address steering (zero when not reading).
    always_comb begin
        read     = 1'b0;
        rom_addr = '0;
        if ((state == ST_OWNED) && req[owner]) begin
            read     = 1'b1;
            rom_addr = req_addr[int'(owner)*ADDR_W +: ADDR_W];
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Testbench for sprite_rom_arbiter: directed vector table, a full
// round-robin rotation sequence, and randomized traffic against a
// transaction-level reference model.
module tb_sprite_rom_arbiter;

    localparam int MAX_BURST = 8;

    logic        Clk;
    logic        Reset;
    logic [2:0]  req;
    logic [20:0] req_addr;
    logic [2:0]  gnt;
    logic [2:0]  rd_valid;
    logic [31:0] rd_data;
    logic [6:0]  rom_addr;
    logic [31:0] rom_data;

    int total;
    int bad;

    sprite_rom_arbiter #(
        .NUM_REQ  (3),
        .ADDR_W   (7),
        .DATA_W   (32),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (req),
        .req_addr(req_addr),
        .gnt     (gnt),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rom_addr(rom_addr),
        .rom_data(rom_data)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM contents: nonzero and distinct for every address.
    function automatic logic [31:0] rom_word(input logic [6:0] a);
        return 32'(32'h9E3779B9 * (32'(a) + 32'd1));
    endfunction

    assign rom_data = rom_word(rom_addr);

    function automatic logic [20:0] pack(input int a0, input int a1, input int a2);
        return {7'(a2), 7'(a1), 7'(a0)};
    endfunction

    function automatic logic [6:0] slice(input logic [20:0] a, input int i);
        return a[i*7 +: 7];
    endfunction

    // ---------------- reference model ----------------
    int          m_owner;   // -1 when nobody owns the ROM
    int          m_ptr;
    int          m_reads;   // reads completed in the current burst window
    logic [2:0]  m_rv;
    logic [31:0] m_rd;
    logic [6:0]  m_ra;
    logic [6:0]  ra_seen;

    function automatic logic [2:0] bit_of(input int i);
        return (i < 0) ? 3'b000 : 3'(1 << i);
    endfunction

    function automatic int first_from(input logic [2:0] set, input int start);
        for (int k = 0; k < 3; k++) begin
            if (set[2'((start + k) % 3)]) return (start + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [6:0] model_ra(input logic [2:0] r, input logic [20:0] a);
        if (m_owner >= 0 && r[2'(m_owner)]) return slice(a, m_owner);
        return 7'd0;
    endfunction

    task automatic model_step(input logic rst, input logic [2:0] r, input logic [20:0] a);
        bit handoff;
        handoff = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_reads = 0; m_rv = '0; m_rd = '0;
            return;
        end
        m_rv = '0;
        if (m_owner < 0) begin
            m_owner = first_from(r, m_ptr);
            m_reads = 0;
        end else begin
            if (r[2'(m_owner)]) begin
                m_rv = bit_of(m_owner);
                m_rd = rom_word(slice(a, m_owner));
                m_reads++;
                if (m_reads == MAX_BURST) begin
                    m_reads = 0;
                    if ((r & ~bit_of(m_owner)) != 3'b000) handoff = 1'b1;
                end
            end else begin
                handoff = 1'b1;
            end
            if (handoff) begin
                m_ptr   = (m_owner + 1) % 3;
                m_owner = first_from(r & ~bit_of(m_owner), m_ptr);
                m_reads = 0;
            end
        end
    endtask

    // One clock: drive inputs, capture combinational rom_addr, advance model, sample after edge.
    task automatic run_cycle(input logic rst, input logic [2:0] r, input logic [20:0] a);
        Reset    = rst;
        req      = r;
        req_addr = a;
        #1;
        ra_seen = rom_addr;
        m_ra    = model_ra(r, a);
        model_step(rst, r, a);
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [20:0] addr;
        logic [2:0]  gnt;
        logic [2:0]  rv;
        logic [31:0] rd;
        logic [6:0]  ra;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [2:0] r, input logic [20:0] a,
                       input logic [2:0] g, input logic [2:0] rv, input logic [31:0] rd,
                       input logic [6:0] ra);
        vec_t v;
        v.rst = rst; v.req = r; v.addr = a; v.gnt = g; v.rv = rv; v.rd = rd; v.ra = ra;
        vecs.push_back(v);
    endtask

    initial begin
        logic [2:0]  r;
        logic [20:0] a;
        int          o;
        int          ph;

        total = 0;
        bad   = 0;
        Clk   = 1'b0;
        Reset = 1'b1;
        req   = '0;
        req_addr = '0;
        m_owner = -1; m_ptr = 0; m_reads = 0; m_rv = '0; m_rd = '0; m_ra = '0;

        // Single requester: grant, reads 32..41 held past the burst limit, then idle return.
        add(1, 3'b000, pack(0, 0, 0), 3'b000, 3'b000, 32'd0, 7'd0);
        add(0, 3'b001, pack(32, 0, 0), 3'b001, 3'b000, 32'd0, 7'd0);
        for (int k = 0; k < 10; k++)
            add(0, 3'b001, pack(32 + k, 0, 0), 3'b001, 3'b001, rom_word(7'(32 + k)), 7'(32 + k));
        add(0, 3'b000, pack(0, 0, 0), 3'b000, 3'b000, rom_word(7'd41), 7'd0);
        add(0, 3'b000, pack(0, 0, 0), 3'b000, 3'b000, rom_word(7'd41), 7'd0);

        // Reset mid-burst with the player owning at counter 3.
        add(1, 3'b000, pack(0, 0, 0), 3'b000, 3'b000, 32'd0, 7'd0);
        add(0, 3'b010, pack(0, 5, 0), 3'b010, 3'b000, 32'd0, 7'd0);
        for (int k = 5; k < 8; k++)
            add(0, 3'b010, pack(0, k, 0), 3'b010, 3'b010, rom_word(7'(k)), 7'(k));
        add(1, 3'b010, pack(0, 8, 0), 3'b000, 3'b000, 32'd0, 7'd8);
        add(0, 3'b010, pack(0, 9, 0), 3'b010, 3'b000, 32'd0, 7'd0);
        add(0, 3'b010, pack(0, 10, 0), 3'b010, 3'b010, rom_word(7'd10), 7'd10);

        // Early drop by background with enemy waiting, then enemy release wraps to background.
        add(1, 3'b000, pack(0, 0, 0), 3'b000, 3'b000, 32'd0, 7'd0);
        add(0, 3'b101, pack(1, 0, 50), 3'b001, 3'b000, 32'd0, 7'd0);
        for (int k = 1; k < 4; k++)
            add(0, 3'b101, pack(k, 0, 50), 3'b001, 3'b001, rom_word(7'(k)), 7'(k));
        add(0, 3'b100, pack(0, 0, 50), 3'b100, 3'b000, rom_word(7'd3), 7'd0);
        add(0, 3'b100, pack(0, 0, 50), 3'b100, 3'b100, rom_word(7'd50), 7'd50);
        add(0, 3'b101, pack(4, 0, 51), 3'b100, 3'b100, rom_word(7'd51), 7'd51);
        add(0, 3'b001, pack(4, 0, 0), 3'b001, 3'b000, rom_word(7'd51), 7'd0);
        add(0, 3'b001, pack(4, 0, 0), 3'b001, 3'b001, rom_word(7'd4), 7'd4);

        // Bring the DUT out of its power-up state before any checks.
        run_cycle(1, 3'b000, '0);
        run_cycle(1, 3'b000, '0);

        foreach (vecs[i]) begin
            run_cycle(vecs[i].rst, vecs[i].req, vecs[i].addr);
            check($sformatf("vec%0d_rom_addr", i), 32'(ra_seen), 32'(vecs[i].ra));
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
            check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].rd);
        end

        // All three request from idle: 8 reads each, rotating with no bubble.
        run_cycle(1, 3'b000, '0);
        run_cycle(0, 3'b111, '0);
        check("rr_first_gnt", 32'(gnt), 32'(3'b001));
        for (int n = 0; n < 36; n++) begin
            o  = (n / 8) % 3;
            ph = n % 8;
            run_cycle(0, 3'b111, pack(ph, 10 + ph, 20 + ph));
            check($sformatf("rr%0d_rom_addr", n), 32'(ra_seen), 32'(10 * o + ph));
            check($sformatf("rr%0d_rd_valid", n), 32'(rd_valid), 32'(bit_of(o)));
            check($sformatf("rr%0d_rd_data", n), rd_data, rom_word(7'(10 * o + ph)));
            check($sformatf("rr%0d_gnt", n), 32'(gnt), 32'(bit_of(((n + 1) / 8) % 3)));
        end

        // Randomized traffic against the reference model.
        run_cycle(1, 3'b000, '0);
        r = 3'b000;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            a = 21'($urandom);
            run_cycle(($urandom_range(0, 255) == 0) ? 1'b1 : 1'b0, r, a);
            check($sformatf("rnd%0d_rom_addr", c), 32'(ra_seen), 32'(m_ra));
            check($sformatf("rnd%0d_gnt", c), 32'(gnt), 32'(bit_of(m_owner)));
            check($sformatf("rnd%0d_rd_valid", c), 32'(rd_valid), 32'(m_rv));
            check($sformatf("rnd%0d_rd_data", c), rd_data, m_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
